irq_controller: RTL
===================

Name: irq_controller

Overview:
- Interrupt controller that sits between the raw button interrupt sources and the pipelined CPU.
- Synchronises, debounces and edge-detects each source, then latches it as pending.
- Arbitrates by fixed priority with nesting; presents one request, source id and vector to the CPU, and tracks in-service levels until the CPU returns from the handler.
- Drives the IRW "waiting" indicators.

Parameters:
N_IRQ, 3, number of interrupt sources (2..4); index N_IRQ-1 has the highest priority.
DB_CYCLES, 4, consecutive stable cycles required before the debounced level changes (>=1).
WIDTH, 32, vector width.
VEC_BASE, 32'h0000_0100, vector of source 0.
VEC_STRIDE, 32'h0000_0010, address step between consecutive source vectors.

Ports:
clk  in  1  CPU clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset.
irq_in  in  N_IRQ  raw asynchronous button levels; active high.
ie  in  1  global interrupt enable from the CPU.
int_ack  in  1  one-cycle pulse: CPU has taken the interrupt and saved EPC.
int_eret  in  1  one-cycle pulse: CPU executed the return-from-interrupt.
int_req  out  1  registered interrupt request to the CPU.
int_id  out  2  id of the requested source; valid while int_req=1.
int_vector  out  WIDTH  equals VEC_BASE + int_id*VEC_STRIDE; registered together with int_id.
irw  out  N_IRQ  pending bits (interrupt waiting), for LEDs.
isr  out  N_IRQ  in-service bits.
busy  out  1  OR of isr.

Behaviour:
- Reset (rst=0 at an edge):
  - Sync flops, debounce counters, debounced levels, delayed levels, pending, isr: all 0.
  - FSM to IDLE; int_req=0, int_id=0, int_vector=VEC_BASE.
  - Reset applied mid-request or mid-handler discards everything.
  - An input held high through reset produces exactly one interrupt afterwards.
- Per-source front end:
  - s1 <= irq_in; s2 <= s1.
  - If s2 == flt, cnt <= 0.
  - Otherwise, if cnt == DB_CYCLES-1, then flt <= s2 and cnt <= 0; else cnt <= cnt+1.
  - rise = flt & ~flt_d, with flt_d <= flt.
  - Only rising edges interrupt. Bounces shorter than DB_CYCLES are ignored.
- Pending:
  - pending[i] is set on rise[i] and cleared when int_ack grants source i.
  - If set and clear hit the same cycle, set wins: bit stays 1 and the new edge is not lost.
  - A repeated edge while already pending coalesces (no counting).
- Level and eligibility:
  - cur = highest index with isr set, or -1 when isr == 0.
  - Source i is eligible when pending[i] = 1 and i > cur.
  - Winner = highest eligible index.
- FSM (2 states):
  - IDLE: if ie=1 and any source is eligible, go to REQ at the next edge; int_req <= 1, int_id <= winner, int_vector <= vector of winner.
  - REQ:
    - int_id and int_vector stay frozen until ack, even if a higher-priority source becomes eligible meanwhile; that source is served afterwards.
    - On int_ack: clear pending[int_id], set isr[int_id], int_req <= 0, go to IDLE.
    - If ie=0 with no ack: withdraw, int_req <= 0, go to IDLE; the pending bit is kept.
    - If ack and ie=0 arrive together, the ack wins.
- Minimum gap: at least one IDLE cycle between consecutive requests.
- int_ack outside REQ is ignored.
- int_eret:
  - Clears the highest set isr bit; ignored when isr == 0.
  - If int_eret and int_ack arrive together, eret is computed on the old isr, then the ack bit is set.
- Latency:
  - irq_in first sampled high at edge k gives flt=1 at edge k+1+DB_CYCLES, pending at k+2+DB_CYCLES, int_req at k+3+DB_CYCLES.
  - For DB_CYCLES=4 that is k+7.
- Outputs: irw = pending, isr = in-service bits, busy = |isr; all are registered values.

Test Plan:
- Reset release, IRQ0 held high since before reset, ie=1 -> int_req rises 7 edges after first sample; int_id=0, int_vector=0x100. Ack -> isr=001, irw=000, busy=1.
- IRQ0 glitch of 3 cycles with DB_CYCLES=4 -> flt never changes; irw stays 000; no int_req.
- Nesting: IRQ0 in service; IRQ2 edge -> request id=2, vector=0x120; ack -> isr=101. eret -> isr=001; second eret -> isr=000.
- Priority block: IRQ2 in service, IRQ1 edge -> irw=010, no request. eret -> id=1 requested on the edge after the next.
- Withdraw and re-assert: request for id=1 outstanding, ie drops -> int_req=0, irw=010 kept. ie returns -> request id=1 again.
- Simultaneous: new IRQ1 edge in the same cycle as the ack for id=1 -> irw[1] stays 1, isr[1]=1, no further request until isr[1] clears. eret together with ack of id=2 while isr=001 -> isr=100.

Source files
------------

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// Fixed-priority nesting interrupt controller: synchronise, debounce and edge-detect
// each button source, latch it as pending, then request, grant and track in-service levels.
module irq_controller #(
  parameter int                N_IRQ      = 3,
  parameter int                DB_CYCLES  = 4,
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  VEC_BASE   = 32'h0000_0100,
  parameter logic [WIDTH-1:0]  VEC_STRIDE = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ie,
  input  logic             int_ack,
  input  logic             int_eret,
  output logic             int_req,
  output logic [1:0]       int_id,
  output logic [WIDTH-1:0] int_vector,
  output logic [N_IRQ-1:0] irw,
  output logic [N_IRQ-1:0] isr,
  output logic             busy
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state, state_next;
  logic [N_IRQ-1:0] s1, s2, flt, flt_d, rise;
  logic [CW-1:0]    cnt [N_IRQ];
  logic [N_IRQ-1:0] pending, pending_next, isr_next;
  logic [N_IRQ-1:0] elig, eret_mask, ack_mask;
  logic             blocked, grant, req_next;
  logic [1:0]       win, id_next;
  logic [WIDTH-1:0] vec_next;

  // A source's filtered level only flips after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= '0;
      s2    <= '0;
      flt   <= '0;
      flt_d <= '0;
      for (int i = 0; i < N_IRQ; i++) cnt[i] <= '0;
    end else begin
      s1    <= irq_in;
      s2    <= s1;
      flt_d <= flt;
      for (int i = 0; i < N_IRQ; i++) begin
        if (s2[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          flt[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = flt & ~flt_d;

  // Anything at or below the highest in-service level is blocked.
  always_comb begin
    blocked   = 1'b0;
    elig      = '0;
    win       = '0;
    eret_mask = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (isr[i]) blocked = 1'b1;
      elig[i] = pending[i] & ~blocked;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      if (elig[i]) win = 2'(i);
      if (isr[i]) begin
        eret_mask    = '0;
        eret_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_next   = int_req;
    id_next    = int_id;
    vec_next   = int_vector;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (ie && (|elig)) begin
          state_next = REQ;
          req_next   = 1'b1;
          id_next    = win;
          vec_next   = VEC_BASE + WIDTH'(win) * VEC_STRIDE;
        end
      end
      REQ: begin
        if (int_ack) begin
          grant      = 1'b1;
          state_next = IDLE;
          req_next   = 1'b0;
        end else if (!ie) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new edge in the grant cycle re-sets pending; eret acts on the old isr before the grant bit.
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < N_IRQ; i++) ack_mask[i] = grant && (int_id == 2'(i));
    pending_next = (pending & ~ack_mask) | rise;
    isr_next     = isr;
    if (int_eret) isr_next = isr_next & ~eret_mask;
    isr_next = isr_next | ack_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= '0;
      int_vector <= VEC_BASE;
      pending    <= '0;
      isr        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      int_req    <= req_next;
      int_id     <= id_next;
      int_vector <= vec_next;
      pending    <= pending_next;
      isr        <= isr_next;
      busy       <= |isr_next;
    end
  end

  assign irw = pending;

endmodule
